// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular FIFO of (pc, instr) pairs between fetch and decode.
// Valid/ready on both sides; a flush discards every queued entry in one cycle.
module fetch_queue #(
  parameter int unsigned WORD  = 64,
  parameter int unsigned INSTR = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD-1:0]          in_pc,
  input  logic [INSTR-1:0]         in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD-1:0]          out_pc,
  output logic [INSTR-1:0]         out_instr,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WORD-1:0]  r_pc_mem    [DEPTH];
  logic [INSTR-1:0] r_instr_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;

  // Handshakes use only registered flags, so in_ready never depends on out_ready.
  assign w_push = in_valid && r_in_ready;
  assign w_pop  = r_out_valid && out_ready;

  // Next pointer/occupancy; flush overrides any same-cycle push or pop.
  always_comb begin
    w_count_nxt  = r_count;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (flush) begin
      w_count_nxt  = '0;
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
    end else begin
      if (w_push) w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
      if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Status flags are registered alongside count so all three change on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt != CNT_W'(DEPTH));
      r_out_valid <= (w_count_nxt != CNT_W'(0));
    end
  end

  // Storage is never cleared; only pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_pc_mem[r_wr_ptr]    <= in_pc;
      r_instr_mem[r_wr_ptr] <= in_instr;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign count     = r_count;
  assign out_pc    = r_out_valid ? r_pc_mem[r_rd_ptr]    : '0;
  assign out_instr = r_out_valid ? r_instr_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        flush;
  logic [2:0]  count;

  int checks;
  int errors;

  fetch_queue #(.WORD(64), .INSTR(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .flush(flush), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_pc = '0; in_instr = '0;
    step(); step();
    reset = 1'b1;
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    checks++; if (out_pc !== 64'h0) begin errors++; $display("FAIL reset_out_pc: got %0h expected 0", out_pc); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr: got %0h expected 0", out_instr); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_pc = 64'h100; in_instr = 32'h8B02_0020;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b expected 1", out_valid); end
    checks++; if (out_pc !== 64'h100) begin errors++; $display("FAIL single_pc: got %0h expected 100", out_pc); end
    checks++; if (out_instr !== 32'h8B02_0020) begin errors++; $display("FAIL single_instr: got %0h expected 8b020020", out_instr); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'h100 || out_instr !== 32'h8B02_0020) begin
        errors++; $display("FAIL single_hold%0d: got v=%0b pc=%0h instr=%0h expected v=1 pc=100 instr=8b020020",
                           i, out_valid, out_pc, out_instr);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %0b expected 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_pop_count: got %0d expected 0", count); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 64'(4 * i); in_instr = 32'(32'h1000 + i);
      step();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %0b expected 0", in_ready); end
    in_pc = 64'h10; in_instr = 32'hFFFF_FFFF;
    step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_overflow_count: got %0d expected 4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'(4 * i) || out_instr !== 32'(32'h1000 + i)) begin
        errors++; $display("FAIL fill_order%0d: got v=%0b pc=%0h instr=%0h expected v=1 pc=%0h instr=%0h",
                           i, out_valid, out_pc, out_instr, 4 * i, 32'h1000 + i);
      end
      step();
    end
    out_ready = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL fill_drained: got count=%0d v=%0b expected 0 0", count, out_valid); end
  endtask

  task automatic test_stream();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_pc = 64'(4 * i); in_instr = 32'(32'hA000 + i);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'(4 * i) || out_instr !== 32'(32'hA000 + i) || count !== 3'd1) begin
        errors++; $display("FAIL stream%0d: got v=%0b pc=%0h instr=%0h count=%0d expected v=1 pc=%0h instr=%0h count=1",
                           i, out_valid, out_pc, out_instr, count, 4 * i, 32'hA000 + i);
      end
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_drain: got %0d expected 0", count); end
  endtask

  task automatic test_full_pop_push();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 64'(32'h30 + 4 * i); in_instr = 32'(32'hB000 + i);
      step();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fpp_full: got %0d expected 4", count); end
    in_valid = 1'b1; out_ready = 1'b1; in_pc = 64'h40; in_instr = 32'hB0FF;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fpp_count: got %0d expected 3", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fpp_in_ready: got %0b expected 1", in_ready); end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'(32'h30 + 4 * i)) begin
        errors++; $display("FAIL fpp_order%0d: got v=%0b pc=%0h expected v=1 pc=%0h", i, out_valid, out_pc, 32'h30 + 4 * i);
      end
      step();
    end
    out_ready = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL fpp_no_0x40: got count=%0d v=%0b expected 0 0", count, out_valid); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 64'(32'h50 + 4 * i); in_instr = 32'(32'hC000 + i);
      step();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_pc = 64'h200; in_instr = 32'hDEAD;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %0b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %0b expected 1", in_ready); end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h200 || out_instr !== 32'hDEAD || count !== 3'd1) begin
      errors++; $display("FAIL flush_new_head: got v=%0b pc=%0h instr=%0h count=%0d expected v=1 pc=200 instr=dead count=1",
                         out_valid, out_pc, out_instr, count);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_pc = 64'(32'h70 + 4 * i); in_instr = 32'(32'hD000 + i);
      step();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL async_pre_count: got %0d expected 2", count); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL async_count: got %0d expected 0", count); end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 64'h0) begin
      errors++; $display("FAIL async_flags: got v=%0b rdy=%0b pc=%0h expected v=0 rdy=1 pc=0", out_valid, in_ready, out_pc);
    end
    #1;
    reset = 1'b1;
    step();
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL async_release: got count=%0d v=%0b expected 0 0", count, out_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_full_pop_push();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the PC register/instruction-memory read in the fetch stage and the decode stage. Each fetched (PC, instruction) pair is pushed into a small circular FIFO with a valid/ready handshake on both sides. Decode can stall without stalling the PC register every cycle, and a branch redirect can flush every queued entry in one cycle.

## Interface
- WORD, 64, width of a PC value
- INSTR, 32, width of an instruction word
- DEPTH, 4, number of entries; power of two, at least 2
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- in_valid  input  1  fetch side presents a valid (in_pc, in_instr) pair
- in_ready  output  1  queue can accept a push this cycle
- in_pc  input  WORD  PC of the fetched instruction
- in_instr  input  INSTR  fetched instruction word
- out_valid  output  1  head entry is valid for decode
- out_ready  input  1  decode consumes the head entry this cycle
- out_pc  output  WORD  PC of the head entry
- out_instr  output  INSTR  instruction of the head entry
- flush  input  1  synchronous discard of all entries (branch redirect)
- count  output  $clog2(DEPTH)+1  number of valid entries

## Operation
- Storage is DEPTH entries of {pc, instr}, with a write pointer, a read pointer and an occupancy counter. Both pointers wrap modulo DEPTH.
- Push happens when in_valid && in_ready. The pair is written at the write pointer, and the write pointer advances.
- Pop happens when out_valid && out_ready. The read pointer advances.
- Push and pop in the same cycle leave count unchanged; both pointers advance.
- in_ready = (count != DEPTH). It depends only on registered state, never on out_ready. When the queue is full, a same-cycle pop does not enable a push.
- out_valid = (count != 0).
- out_pc and out_instr come from the entry at the read pointer when out_valid=1. They are 0 when out_valid=0.
- Head data holds stable while out_valid=1 and out_ready=0.
- No bypass path: a push into an empty queue is visible at the output on the next cycle.
- flush=1 at a rising edge:
  - count, write pointer and read pointer all go to 0.
  - A push or pop in the same cycle is discarded.
  - flush has priority over every other event.
- Storage contents are never cleared by flush. Only the pointers and count matter.
- In-flight state is ignored; no partial completion.

## Timing
- Reset (reset=0), asynchronous:
  - count=0, both pointers=0, out_valid=0, in_ready=1, out_pc=0, out_instr=0.
  - Takes effect immediately, without waiting for a clock edge.
  - Reset mid-operation drops all entries.
- Release on reset 0->1: the first push can occur at the next rising edge.
- Latency from push to out_valid=1: 1 cycle.
- Throughput: one push and one pop per cycle when 0 < count < DEPTH.
- count, in_ready and out_valid all update on the same rising edge as the pointers.
- Full: count=DEPTH, in_ready=0, in_pc/in_instr ignored.
- Empty: count=0, out_valid=0, out_ready ignored.
- Pointers wrap from DEPTH-1 to 0 with no bubble.
- After flush: the next cycle shows out_valid=0 and in_ready=1.

## Test plan
- Reset and release:
  - Hold reset=0 for 2 cycles, then release. Check count=0, out_valid=0, in_ready=1, out_pc=0, out_instr=0.
  - Assert reset=0 between clock edges with 2 entries queued. Check that count goes to 0 before the next edge.
- Single entry, out_ready=0:
  - Push pc=0x100, instr=0x8B020020. Next cycle: out_valid=1, out_pc=0x100, out_instr=0x8B020020, count=1.
  - Head holds for 3 cycles. Raise out_ready for 1 cycle, then check out_valid=0.
- Fill to full:
  - Push PCs 0x0, 0x4, 0x8, 0xC with out_ready=0. Check count=4 and in_ready=0.
  - A 5th push of 0x10 is ignored.
  - Pop all four and check the order 0x0, 0x4, 0x8, 0xC.
- Wrap-around streaming:
  - Hold in_valid=1 and out_ready=1 for 10 cycles with PCs 0x0..0x24 step 4.
  - Outputs match in order, one per cycle after 1 cycle of latency. count stays 1.
- Full plus pop plus push in one cycle:
  - At count=4, assert out_ready=1 and in_valid=1 with pc=0x40.
  - Head pops, 0x40 is not accepted, count=3.
- Flush priority:
  - With 3 entries queued, assert flush, in_valid (pc=0x200) and out_ready together.
  - Next cycle: count=0, out_valid=0.
  - A push of 0x200 on the following cycle appears as the new head.
